// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state encoding and default width for the serial shift-register link
// Contents:
//   ST_IDLE / ST_SHIFT : link state encoding shared by transmitter, receiver and benches
//   SER_LINK_WIDTH     : default serial-link word width
//   ser_state_e        : enumerated state type built on the shared encoding
package piso_serializer_pkg;

    localparam logic ST_IDLE        = 1'b0;
    localparam logic ST_SHIFT       = 1'b1;
    localparam int   SER_LINK_WIDTH = 4;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } ser_state_e;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// rtl/piso_serializer_bit_counter.sv - bit index counter for one serial frame
// Ports:
//   clk     in  clock
//   reset   in  synchronous active-high reset, clears the count
//   clear   in  synchronous clear, wins over inc
//   inc     in  advance the bit index by one
//   cnt     out current bit index, 0..WIDTH-1
//   at_last out cnt == WIDTH-1
module ser_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     at_last
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_last = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready intake
// Ports:
//   clk        in  clock, all state updates on posedge
//   reset      in  synchronous active-high reset, aborts any frame in flight
//   pdata      in  parallel word, sampled only on accept (pvalid && pready)
//   pvalid     in  upstream holds a word on pdata
//   pready     out block can accept a word this cycle
//   sout       out serial data bit, 0 when idle
//   sout_valid out sout carries a frame bit
//   last       out sout carries the final bit of the word
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = SER_LINK_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pdata,
    input  logic             pvalid,
    output logic             pready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             in_shift;
    logic             accept;
    logic             send_bit;

    assign in_shift = (state_q == S_SHIFT);
    // Ready on the final bit as well, so a held word reloads with no idle gap.
    assign pready   = !in_shift || at_last;
    assign accept   = pvalid && pready;

    ser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept || (in_shift && at_last)),
        .inc     (in_shift && !at_last),
        .cnt     (cnt),
        .at_last (at_last)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        if (accept) begin
            shreg_d = pdata;
            state_d = S_SHIFT;
        end else if (in_shift) begin
            // Move the next bit to the send end; the vacated end fills with 0.
            if (LSB_FIRST) begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end
            if (at_last) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    assign send_bit   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    assign sout       = in_shift && send_bit;
    assign sout_valid = in_shift;
    assign last       = in_shift && at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pdata, pdata_l;
    logic       pvalid, pvalid_l;
    logic       pready, sout, sout_valid, last;
    logic       pready_l, sout_l, sout_valid_l, last_l;
    logic [3:0] rx_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .pdata      (pdata),
        .pvalid     (pvalid),
        .pready     (pready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (last)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .pdata      (pdata_l),
        .pvalid     (pvalid_l),
        .pready     (pready_l),
        .sout       (sout_l),
        .sout_valid (sout_valid_l),
        .last       (last_l)
    );

    // 4-bit SIPO receiver on the same clk/reset, shifting in every cycle.
    always_ff @(posedge clk) begin
        if (reset) rx_q <= 4'h0;
        else       rx_q <= {rx_q[2:0], sout};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pvalid = 1'b0; pdata = 4'h0; pvalid_l = 1'b0; pdata_l = 4'h0;
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if ({sout, sout_valid, last, pready} !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: {sout,sout_valid,last,pready}=%b required 0001", c, {sout, sout_valid, last, pready});
            end
            n_checks++;
            if ({sout_l, sout_valid_l, last_l, pready_l} !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset_outputs_lsb cycle %0d: got %b required 0001", c, {sout_l, sout_valid_l, last_l, pready_l});
            end
            tick();
        end
    endtask

    task automatic test_single_word();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        pdata = 4'b1011; pvalid = 1'b1;
        tick();
        pvalid = 1'b0; pdata = 4'h0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({sout_valid, sout, last, pready} !== {1'b1, exp_bits[3-i], i == 3, i == 3}) begin
                n_fail++;
                $display("FAIL single_bit%0d: {valid,sout,last,pready}=%b required %b", i, {sout_valid, sout, last, pready}, {1'b1, exp_bits[3-i], i == 3, i == 3});
            end
            tick();
        end
        n_checks++;
        if ({sout, sout_valid, last, pready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_idle: got %b required 0001", {sout, sout_valid, last, pready});
        end
    endtask

    task automatic test_loopback();
        logic [3:0] exp_bits;
        exp_bits = 4'hA;
        pdata = 4'hA; pvalid = 1'b1;
        tick();
        pvalid = 1'b0; pdata = 4'h0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sout !== exp_bits[3-i]) begin
                n_fail++;
                $display("FAIL loop_bit%0d: sout=%b required %b", i, sout, exp_bits[3-i]);
            end
            tick();
        end
        n_checks++;
        if (rx_q !== 4'hA) begin
            n_fail++;
            $display("FAIL loopback_rx: rx=%h required a", rx_q);
        end
        n_checks++;
        if (sout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL loopback_idle: sout_valid=%b required 0", sout_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits;
        exp_bits = 8'b0011_1100;
        pdata = 4'h3; pvalid = 1'b1;
        tick();
        pdata = 4'hC;
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if ({sout_valid, sout, last, pready} !== {1'b1, exp_bits[7-j], j % 4 == 3, j % 4 == 3}) begin
                n_fail++;
                $display("FAIL stream_bit%0d: {valid,sout,last,pready}=%b required %b", j, {sout_valid, sout, last, pready}, {1'b1, exp_bits[7-j], j % 4 == 3, j % 4 == 3});
            end
            if (j == 7) pvalid = 1'b0;
            tick();
        end
        n_checks++;
        if ({sout_valid, last, pready} !== 3'b001) begin
            n_fail++;
            $display("FAIL stream_end: {valid,last,pready}=%b required 001", {sout_valid, last, pready});
        end
    endtask

    task automatic test_busy_and_reset();
        int last_seen;
        pdata = 4'hF; pvalid = 1'b1;
        tick();
        pvalid = 1'b0;
        tick();
        // Bit 1 on the line: offer a different word while busy.
        pdata = 4'h0; pvalid = 1'b1;
        n_checks++;
        if (pready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_pready: pready=%b required 0", pready);
        end
        tick();
        pvalid = 1'b0;
        n_checks++;
        if ({sout_valid, sout, last} !== 3'b110) begin
            n_fail++;
            $display("FAIL busy_ignore: {valid,sout,last}=%b required 110", {sout_valid, sout, last});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({sout, sout_valid, last, pready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b required 0001", {sout, sout_valid, last, pready});
        end
        last_seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (last || sout_valid) last_seen++;
            tick();
        end
        n_checks++;
        if (last_seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: active cycles=%0d required 0", last_seen);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp_bits;
        exp_bits = 4'b0001;
        pdata_l = 4'b0001; pvalid_l = 1'b1;
        tick();
        pvalid_l = 1'b0; pdata_l = 4'h0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({sout_valid_l, sout_l, last_l} !== {1'b1, exp_bits[i], i == 3}) begin
                n_fail++;
                $display("FAIL lsb_bit%0d: {valid,sout,last}=%b required %b", i, {sout_valid_l, sout_l, last_l}, {1'b1, exp_bits[i], i == 3});
            end
            tick();
        end
        n_checks++;
        if ({sout_valid_l, pready_l} !== 2'b01) begin
            n_fail++;
            $display("FAIL lsb_idle: {valid,pready}=%b required 01", {sout_valid_l, pready_l});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_loopback();
        test_back_to_back();
        test_busy_and_reset();
        test_lsb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
